instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-side producer for the main control decoder. Holds the PC, fetches 32-bit words over a req/ack
//  instruction-memory port and buffers them in a small FIFO. Presents instr/opcode/pc to decode with valid/ready.
//  Applies jump/branch redirects returned by the datapath, flushing wrong-path words.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of first fetch after reset
//  BUF_DEPTH  2              FIFO entries (power of 2, >=2); bounds buffered + in-flight words
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req       out  1   fetch request, held until imem_ack
//  imem_addr      out  32  fetch address, word aligned, stable while imem_req=1
//  imem_ack       in   1   response strobe; only meaningful when imem_req=1
//  imem_rdata     in   32  instruction word, valid in the imem_ack cycle
//  instr_valid    out  1   FIFO head valid
//  instr_ready    in   1   decode accepts head (accept = instr_valid & instr_ready)
//  instr          out  32  head instruction word
//  opcode         out  6   instr[31:26], feeds the control decoder
//  pc_out         out  32  PC of head instruction
//  jump           in   1   accepted instr is j; qualified by accept
//  branch         in   1   accepted instr is a taken beq (Branch & Zero); qualified by accept
//  br_offset      in   16  imm field of accepted instr
//  j_index        in   26  target field of accepted instr
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=RESET_PC, FIFO empty, fetch_pc=RESET_PC.
//  FSM: IDLE -> REQ when credit available; REQ holds imem_req=1 until imem_ack; on ack: push word, fetch_pc+=4,
//   then REQ again if credit, else IDLE. At most one request outstanding.
//  Credit: issue only if fifo_count + outstanding < BUF_DEPTH; otherwise stay/return to IDLE, no req.
//  Zero-bubble: ack in cycle N with credit -> imem_req=1 with the next addr in cycle N+1.
//  Head latency: word acked in cycle N is visible with instr_valid=1 in cycle N+1 (registered FIFO output).
//  Full FIFO plus accept in the same cycle frees one slot; credit is evaluated after the pop.
//  Empty FIFO: instr_valid=0; instr/pc_out hold last value.
//  Redirect (accept & (jump|branch)); jump wins if both:
//   jump target   = {pc_out+4}[31:28], j_index, 2'b00
//   branch target = pc_out + 4 + (sext32(br_offset) << 2), mod 2^32 (wrap allowed, no trap)
//   Same edge: FIFO flushed, fetch_pc=target, instr_valid=0 next cycle.
//   Request in flight: imem_req/imem_addr held until ack (no abort); acked word discarded, never pushed.
//   Next request issued the cycle after that ack, at the target address.
//   Ack in the redirect cycle: word discarded.
//  jump/branch without accept: ignored. fetch_pc wraps 32'hFFFF_FFFC -> 0.
//  rst_n low mid-transaction: immediate return to reset state; late ack after reset is ignored (req=0).
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (+1 per ack pushed) and perf_flush_cnt[31:0]
//   (+1 per redirect). Both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  mips_pkg: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010,
//   PC_STEP=4, fetch-state enum {IFU_IDLE, IFU_REQ}.
//  Sub-module ifu_fifo: sync FIFO of {pc,instr}, depth BUF_DEPTH, flush input, count output.
// TESTING
//  1 Reset, ack every cycle, instr_ready=1: addrs 0,4,8,... back-to-back; instr_valid first seen 1 cycle after
//    first ack.
//  2 instr_ready=0, BUF_DEPTH=2: two acks, then imem_req=0. Set ready=1: req resumes the cycle after the pop.
//  3 Accept pc=0x10 with jump=1, j_index=0x40: flush; next imem_addr=0x100; stale words never presented.
//  4 Accept pc=0x20, branch=1, br_offset=16'hFFFE: next fetch 0x1C. br_offset=0x0003: next fetch 0x30.
//  5 Redirect while req pending 3 cycles: addr held, acked word dropped, target requested next cycle.
//  6 Assert rst_n=0 mid-request: all outputs return to reset values asynchronously. With IFU_PERF_CNT_EN,
//    counters are 0 after reset and count 5 acks/1 flush correctly.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcodes, fetch-state encoding, FIFO entry layout and redirect-target helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mips_pkg;

   localparam logic [5:0]  OP_RTYPE = 6'b000000;
   localparam logic [5:0]  OP_LW    = 6'b100011;
   localparam logic [5:0]  OP_SW    = 6'b101011;
   localparam logic [5:0]  OP_BEQ   = 6'b000100;
   localparam logic [5:0]  OP_J     = 6'b000010;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic {
      IFU_IDLE = 1'b0,
      IFU_REQ  = 1'b1
   } ifu_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifu_entry_t;

   // j target: top nibble of the sequential PC, then the 26-bit word index
   function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
      logic [31:0] pc_inc;
      pc_inc = pc + PC_STEP;
      return {pc_inc[31:28], idx, 2'b00};
   endfunction

   // beq target: sequential PC plus sign-extended word offset, wrapping mod 2^32
   function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] off);
      logic [31:0] sext;
      sext = {{16{off[15]}}, off};
      return pc + PC_STEP + (sext << 2);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory req/ack port and the decode-side valid/ready port.
// Latency: n/a (wires only).
// Backpressure: imem side held by imem_req until imem_ack; decode side by instr_ready.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic        jump;
   logic        branch;
   logic [15:0] br_offset;
   logic [25:0] j_index;

   // fetch unit side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
      input  imem_ack, imem_rdata, instr_ready, jump, branch, br_offset, j_index
   );

   // memory + decoder side
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
      output imem_ack, imem_rdata, instr_ready, jump, branch, br_offset, j_index
   );
endinterface

// File: rtl/ifu_fifo.sv
// Sync FIFO of {pc,instr} with flush; head held in registers so it survives going empty.
// Latency: a push is visible at the head the next cycle.
// Backpressure: caller guarantees no push when full; pop on empty is ignored; flush wins.
module ifu_fifo
   import mips_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  ifu_entry_t                 i_push_dat,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic                       o_vld,
   output ifu_entry_t                 o_dat,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ifu_entry_t          r_mem [DEPTH];
   ifu_entry_t          r_head;
   ifu_entry_t          w_head_nxt;
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW-1:0]       w_wr_ptr_nxt;
   logic [AW-1:0]       w_rd_ptr_nxt;
   logic [CW-1:0]       r_count;
   logic [CW-1:0]       w_count_nxt;
   logic                w_pop_ok;

   assign w_pop_ok = i_pop & (r_count != '0);

   // pointer/count update and look-ahead of the head entry after this edge
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(i_push);
      w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop_ok);
      w_count_nxt  = r_count + CW'(i_push) - CW'(w_pop_ok);
      w_head_nxt   = r_head;
      if (i_flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else if (w_count_nxt != '0) begin
         // a word pushed into the slot that becomes the head bypasses storage
         if (i_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = i_push_dat;
         else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   // storage array, no reset needed: only read once written
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
   end

   // control state and head register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_head.pc    <= RESET_PC;
         r_head.instr <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_head   <= w_head_nxt;
      end
   end

   assign o_vld   = (r_count != '0);
   assign o_dat   = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one-outstanding req/ack fetch, FIFO to decode, jump/branch redirect.
// Latency: ack in cycle N -> head valid in N+1; next request in N+1 if credit allows.
// Backpressure: requests only while buffered+in-flight < BUF_DEPTH. Optional IFU_PERF_CNT_EN adds counters.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
)(
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  ifu_bus
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetch_cnt,
   output logic [31:0]         perf_flush_cnt
`endif
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   ifu_state_e    r_state;
   ifu_state_e    w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   w_fetch_pc_nxt;
   logic [31:0]   r_addr;
   logic          r_discard;
   logic          w_discard_nxt;
   logic          w_issue;
   logic          w_accept;
   logic          w_redirect;
   logic          w_ack;
   logic          w_push;
   logic          w_head_vld;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_nxt;
   logic [31:0]   w_target;
   ifu_entry_t    w_head;
   ifu_entry_t    w_push_dat;

   assign w_accept   = w_head_vld & ifu_bus.instr_ready;
   assign w_redirect = w_accept & (ifu_bus.jump | ifu_bus.branch);
   assign w_ack      = (r_state == IFU_REQ) & ifu_bus.imem_ack;
   // words from a redirected-away request, or acked in the redirect cycle, are dropped
   assign w_push     = w_ack & ~r_discard & ~w_redirect;
   assign w_target   = ifu_bus.jump ? jump_target(w_head.pc, ifu_bus.j_index)
                                    : branch_target(w_head.pc, ifu_bus.br_offset);

   assign w_push_dat.pc    = r_addr;
   assign w_push_dat.instr = ifu_bus.imem_rdata;

   // FIFO occupancy after this edge; credit is judged against it
   always_comb begin
      w_count_nxt = w_count + CW'(w_push) - CW'(w_accept);
      if (w_redirect) w_count_nxt = '0;
   end

   // fetch PC: redirect target, else advance on each kept word
   always_comb begin
      w_fetch_pc_nxt = r_fetch_pc;
      if (w_redirect)  w_fetch_pc_nxt = w_target;
      else if (w_push) w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
   end

   // next state: issue a new request whenever the port is free and credit remains
   always_comb begin
      w_state_nxt   = r_state;
      w_issue       = 1'b0;
      w_discard_nxt = r_discard;
      case (r_state)
         IFU_IDLE: begin
            if (w_count_nxt < CW'(BUF_DEPTH)) begin
               w_state_nxt = IFU_REQ;
               w_issue     = 1'b1;
            end
         end
         IFU_REQ: begin
            if (w_ack) begin
               w_discard_nxt = 1'b0;
               if (w_count_nxt < CW'(BUF_DEPTH)) begin
                  w_state_nxt = IFU_REQ;
                  w_issue     = 1'b1;
               end else begin
                  w_state_nxt = IFU_IDLE;
               end
            end else if (w_redirect) begin
               // cannot abort the request: hold it and drop its word later
               w_discard_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IFU_IDLE;
      endcase
   end

   // FSM, fetch PC and request address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IFU_IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_discard  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_discard  <= w_discard_nxt;
         if (w_issue) r_addr <= w_fetch_pc_nxt;
      end
   end

   ifu_fifo #(
      .DEPTH    (BUF_DEPTH),
      .RESET_PC (RESET_PC)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_accept),
      .i_flush    (w_redirect),
      .o_vld      (w_head_vld),
      .o_dat      (w_head),
      .o_count    (w_count)
   );

   assign ifu_bus.imem_req    = (r_state == IFU_REQ);
   assign ifu_bus.imem_addr   = r_addr;
   assign ifu_bus.instr_valid = w_head_vld;
   assign ifu_bus.instr       = w_head.instr;
   assign ifu_bus.opcode      = w_head.instr[31:26];
   assign ifu_bus.pc_out      = w_head.pc;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_flush_cnt;

   // event counters: kept words and redirects, free-running with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'(w_push);
         r_perf_flush_cnt <= r_perf_flush_cnt + 32'(w_redirect);
      end
   end

   assign perf_fetch_cnt = r_perf_fetch_cnt;
   assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, credit stall, jump/branch redirects,
// redirect with a pending request, asynchronous reset mid-request and optional counters.
// Stimulus is driven #1 after each rising edge; outputs are checked at the same point.
module tb_instr_fetch_unit;
   import mips_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_fail;
   int   n_total;

   instr_fetch_unit_if bus();

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifu_bus        (bus.master)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   // memory image: opcode alternates LW/BEQ with address bit 2, low bits carry the word index
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {(a[2] ? OP_BEQ : OP_LW), a[27:2]};
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b0;
      bus.jump        = 1'b0;
      bus.branch      = 1'b0;
      bus.br_offset   = '0;
      bus.j_index     = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      rst_n           = 1'b1;
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b0;
      bus.jump        = 1'b0;
      bus.branch      = 1'b0;
      bus.br_offset   = '0;
      bus.j_index     = '0;
      #1 rst_n = 1'b0;
      #1;
      // ---- reset values
      chk1("rst_req",   bus.imem_req,    1'b0);
      chk ("rst_addr",  bus.imem_addr,   32'h0);
      chk1("rst_valid", bus.instr_valid, 1'b0);
      chk ("rst_instr", bus.instr,       32'h0);
      chk ("rst_pc",    bus.pc_out,      32'h0);

      // ---- 1: back-to-back streaming
      do_reset();
      step();
      chk1("t1_req_first",  bus.imem_req,  1'b1);
      chk ("t1_addr_first", bus.imem_addr, 32'h0);
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b1;
      chk1("t1_valid_before_ack", bus.instr_valid, 1'b0);
      step();
      chk ("t1_addr_1",  bus.imem_addr,   32'h4);
      chk1("t1_valid_1", bus.instr_valid, 1'b1);
      chk ("t1_pc_1",    bus.pc_out,      32'h0);
      chk ("t1_instr_1", bus.instr,       mem_word(32'h0));
      chk ("t1_op_1",    {26'b0, bus.opcode}, {26'b0, OP_LW});
      for (int k = 1; k <= 4; k++) begin
         step();
         chk ("t1_addr_k",  bus.imem_addr,   32'(4 * (k + 1)));
         chk ("t1_pc_k",    bus.pc_out,      32'(4 * k));
         chk ("t1_instr_k", bus.instr,       mem_word(32'(4 * k)));
         chk1("t1_valid_k", bus.instr_valid, 1'b1);
      end

      // ---- 2: credit stall with instr_ready=0, then resume after pop
      do_reset();
      step();
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b0;
      step();
      chk1("t2_req_after_ack1", bus.imem_req,  1'b1);
      chk ("t2_addr_after_ack1", bus.imem_addr, 32'h4);
      step();
      chk1("t2_req_full",  bus.imem_req,    1'b0);
      chk1("t2_valid_full", bus.instr_valid, 1'b1);
      chk ("t2_pc_full",   bus.pc_out,      32'h0);
      bus.imem_ack = 1'b0;
      bus.jump     = 1'b1;
      bus.j_index  = 26'h3FF;
      step();
      chk1("t2_req_still_idle", bus.imem_req, 1'b0);
      chk ("t2_pc_jump_ignored", bus.pc_out,  32'h0);
      bus.jump        = 1'b0;
      bus.instr_ready = 1'b1;
      step();
      chk1("t2_req_resume", bus.imem_req,  1'b1);
      chk ("t2_addr_resume", bus.imem_addr, 32'h8);
      chk ("t2_pc_after_pop", bus.pc_out,   32'h4);

      // ---- 3: jump redirect from pc 0x10
      bus.imem_ack = 1'b1;
      step();
      chk ("t3_pc_8",  bus.pc_out, 32'h8);
      step();
      chk ("t3_pc_c",  bus.pc_out, 32'hC);
      step();
      chk ("t3_pc_10", bus.pc_out, 32'h10);
      chk ("t3_addr_14", bus.imem_addr, 32'h14);
      bus.jump    = 1'b1;
      bus.j_index = 26'h40;
      step();
      chk1("t3_valid_flushed", bus.instr_valid, 1'b0);
      chk1("t3_req_target",    bus.imem_req,    1'b1);
      chk ("t3_addr_target",   bus.imem_addr,   32'h100);
      chk ("t3_pc_hold",       bus.pc_out,      32'h10);
      bus.jump = 1'b0;
      step();
      chk1("t3_valid_target", bus.instr_valid, 1'b1);
      chk ("t3_pc_target",    bus.pc_out,      32'h100);
      chk ("t3_instr_target", bus.instr,       mem_word(32'h100));
      bus.imem_ack = 1'b0;
      step();
      chk1("t3_valid_drained", bus.instr_valid, 1'b0);
      chk ("t3_addr_pending",  bus.imem_addr,   32'h104);

      // ---- 4: branch redirects, negative then positive offset
      do_reset();
      step();
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 9; i++) step();
      chk ("t4_pc_20",   bus.pc_out,    32'h20);
      chk ("t4_addr_24", bus.imem_addr, 32'h24);
      bus.branch    = 1'b1;
      bus.br_offset = 16'hFFFE;
      step();
      chk ("t4_addr_neg",  bus.imem_addr,   32'h1C);
      chk1("t4_valid_neg", bus.instr_valid, 1'b0);
      bus.branch = 1'b0;
      step();
      chk ("t4_pc_1c", bus.pc_out, 32'h1C);
      step();
      chk ("t4_pc_20b",   bus.pc_out,    32'h20);
      chk ("t4_addr_24b", bus.imem_addr, 32'h24);
      bus.branch    = 1'b1;
      bus.br_offset = 16'h0003;
      step();
      chk ("t4_addr_pos",  bus.imem_addr,   32'h30);
      chk1("t4_valid_pos", bus.instr_valid, 1'b0);
      bus.branch = 1'b0;
      step();
      chk1("t4_valid_30", bus.instr_valid, 1'b1);
      chk ("t4_pc_30",    bus.pc_out,      32'h30);

      // ---- 5: redirect while a request stays pending for 3 cycles
      do_reset();
      step();
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b0;
      step();
      chk ("t5_pc_0",   bus.pc_out,    32'h0);
      chk ("t5_addr_4", bus.imem_addr, 32'h4);
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b1;
      bus.jump        = 1'b1;
      bus.j_index     = 26'h80;
      step();
      chk1("t5_valid_flushed", bus.instr_valid, 1'b0);
      chk1("t5_req_held",      bus.imem_req,    1'b1);
      chk ("t5_addr_held_1",   bus.imem_addr,   32'h4);
      bus.jump = 1'b0;
      step();
      chk ("t5_addr_held_2", bus.imem_addr, 32'h4);
      step();
      chk ("t5_addr_held_3", bus.imem_addr, 32'h4);
      bus.imem_ack = 1'b1;
      step();
      chk1("t5_valid_dropped", bus.instr_valid, 1'b0);
      chk1("t5_req_target",    bus.imem_req,    1'b1);
      chk ("t5_addr_target",   bus.imem_addr,   32'h200);
      step();
      chk1("t5_valid_target", bus.instr_valid, 1'b1);
      chk ("t5_pc_target",    bus.pc_out,      32'h200);

      // ---- 6: counters, then asynchronous reset mid-request
      do_reset();
`ifdef IFU_PERF_CNT_EN
      chk ("t6_fetch_cnt_rst", perf_fetch_cnt, 32'd0);
      chk ("t6_flush_cnt_rst", perf_flush_cnt, 32'd0);
`endif
      step();
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk ("t6_pc_10",   bus.pc_out,    32'h10);
      chk ("t6_addr_14", bus.imem_addr, 32'h14);
      bus.imem_ack = 1'b0;
      bus.jump     = 1'b1;
      bus.j_index  = 26'h10;
      step();
      chk1("t6_valid_flushed", bus.instr_valid, 1'b0);
      chk ("t6_addr_held",     bus.imem_addr,   32'h14);
`ifdef IFU_PERF_CNT_EN
      chk ("t6_fetch_cnt_5", perf_fetch_cnt, 32'd5);
      chk ("t6_flush_cnt_1", perf_flush_cnt, 32'd1);
`endif
      bus.jump     = 1'b0;
      bus.imem_ack = 1'b1;
      rst_n        = 1'b0;
      #1;
      chk1("t6_async_req",   bus.imem_req,    1'b0);
      chk ("t6_async_addr",  bus.imem_addr,   32'h0);
      chk1("t6_async_valid", bus.instr_valid, 1'b0);
      chk ("t6_async_instr", bus.instr,       32'h0);
      chk ("t6_async_pc",    bus.pc_out,      32'h0);
`ifdef IFU_PERF_CNT_EN
      chk ("t6_async_fetch_cnt", perf_fetch_cnt, 32'd0);
      chk ("t6_async_flush_cnt", perf_flush_cnt, 32'd0);
`endif
      step();
      rst_n = 1'b1;
      step();
      chk1("t6_late_ack_valid", bus.instr_valid, 1'b0);
      chk1("t6_req_restart",    bus.imem_req,    1'b1);
      chk ("t6_addr_restart",   bus.imem_addr,   32'h0);
      step();
      chk1("t6_valid_restart", bus.instr_valid, 1'b1);
      chk ("t6_pc_restart",    bus.pc_out,      32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
